// File: rtl/data_ram_responder.sv
// data_ram_responder: word-addressed data RAM behind a request/response
// handshake. Requests are accepted while fewer than QUEUE_DEPTH are
// outstanding, and each one is answered exactly LATENCY cycles after acceptance,
// in acceptance order. Loads return the word captured at acceptance; stores
// update byte lanes at acceptance and answer with zero data.
// Optional feature macro: DATA_RAM_RESPONDER_BACKPRESSURE_EN adds a free-running
// 2-bit counter that withholds address_ready whenever it reads 3.
module data_ram_responder #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int LATENCY       = 2,
    parameter int QUEUE_DEPTH   = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_ram_request,
    input  logic        data_ram_write,
    input  logic [1:0]  data_ram_size,
    input  logic [31:0] data_ram_address,
    input  logic [31:0] data_ram_write_data,
    input  logic [3:0]  data_ram_write_strobe,
    output logic        data_ram_address_ready,
    output logic        data_ram_data_ready,
    output logic [31:0] data_ram_read_data
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);

    // Memory contents survive reset, so they live outside the reset domain.
    logic [31:0] mem [2**ADDRESS_WIDTH];

    // Queue slot 0 is always the oldest entry; a pop shifts the rest down.
    logic [QUEUE_DEPTH-1:0] valid_reg, valid_next, shift_valid;
    logic [2:0]             cd_reg    [QUEUE_DEPTH];
    logic [2:0]             cd_next   [QUEUE_DEPTH];
    logic [2:0]             shift_cd  [QUEUE_DEPTH];
    logic [31:0]            data_reg  [QUEUE_DEPTH];
    logic [31:0]            data_next [QUEUE_DEPTH];
    logic [31:0]            shift_data[QUEUE_DEPTH];
    logic [CW-1:0]          count_reg, count_next, push_index;

    logic                     push;
    logic                     pop;
    logic                     slot_free;
    logic [ADDRESS_WIDTH-1:0] word_index;
    logic                     unused_bits;

    // Size and the address bits outside the word index carry no meaning here.
    assign unused_bits = ^{data_ram_size, data_ram_address[1:0],
                           data_ram_address[31:ADDRESS_WIDTH+2]};

    assign word_index = data_ram_address[ADDRESS_WIDTH+1:2];
    assign slot_free  = (count_reg < CW'(QUEUE_DEPTH));

`ifdef DATA_RAM_RESPONDER_BACKPRESSURE_EN
    logic [1:0] bp_count_reg;

    // Free-running counter; every fourth cycle the responder refuses requests.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bp_count_reg <= 2'd0;
        end else begin
            bp_count_reg <= bp_count_reg + 2'd1;
        end
    end

    assign data_ram_address_ready = slot_free && (bp_count_reg != 2'd3);
`else
    assign data_ram_address_ready = slot_free;
`endif

    assign push = data_ram_request && data_ram_address_ready;
    // The head is the only entry that can have reached zero first.
    assign pop  = valid_reg[0] && (cd_reg[0] == 3'd0);

    assign data_ram_data_ready = pop;
    assign data_ram_read_data  = pop ? data_reg[0] : 32'h0;

    // A new entry lands just above whatever survives this cycle's pop.
    assign push_index = count_reg - CW'(pop);
    assign count_next = count_reg + CW'(push) - CW'(pop);

    // Source of each slot when the queue shifts down; the top slot empties.
    genvar gi;
    generate
        for (gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_shift
            if (gi < QUEUE_DEPTH - 1) begin : g_mid
                assign shift_valid[gi] = valid_reg[gi+1];
                assign shift_cd[gi]    = cd_reg[gi+1];
                assign shift_data[gi]  = data_reg[gi+1];
            end else begin : g_top
                assign shift_valid[gi] = 1'b0;
                assign shift_cd[gi]    = 3'd0;
                assign shift_data[gi]  = 32'h0;
            end
        end
    endgenerate

    // Next queue state: shift on pop, count down, then place any new entry.
    always_comb begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            valid_next[i] = pop ? shift_valid[i] : valid_reg[i];
            cd_next[i]    = pop ? shift_cd[i]    : cd_reg[i];
            data_next[i]  = pop ? shift_data[i]  : data_reg[i];
            if (cd_next[i] != 3'd0) begin
                cd_next[i] = cd_next[i] - 3'd1;
            end
            if (push && (push_index == CW'(i))) begin
                valid_next[i] = 1'b1;
                cd_next[i]    = CD_INIT;
                data_next[i]  = data_ram_write ? 32'h0 : mem[word_index];
            end
        end
    end

    // Queue control state; reset discards every outstanding request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                cd_reg[i] <= 3'd0;
            end
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                cd_reg[i] <= cd_next[i];
            end
        end
    end

    // Payload and memory: loads capture the word at acceptance, stores write lanes.
    always_ff @(posedge clock) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            data_reg[i] <= data_next[i];
        end
        if (push && data_ram_write) begin
            for (int b = 0; b < 4; b++) begin
                if (data_ram_write_strobe[b]) begin
                    mem[word_index][8*b +: 8] <= data_ram_write_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_ram_responder.md
DATA_RAM_RESPONDER -- requirements
Module: data_ram_responder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 10, meaning word-index bits of the internal memory (2^ADDRESS_WIDTH 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request acceptance to response (legal range 1..7).
REQ-003 SHALL have parameter QUEUE_DEPTH, default 2, meaning maximum outstanding accepted requests (legal range 1..4).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 SHALL have port clock  input  1  clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-007 SHALL have port data_ram_request  input  1  initiator request valid.
REQ-008 SHALL have port data_ram_write  input  1  1=store, 0=load.
REQ-009 SHALL have port data_ram_size  input  2  access size (0 byte, 1 half, 2 word); informational only.
REQ-010 SHALL have port data_ram_address  input  32  byte address.
REQ-011 SHALL have port data_ram_write_data  input  32  store data, byte-lane aligned.
REQ-012 SHALL have port data_ram_write_strobe  input  4  per-byte write enables.
REQ-013 SHALL have port data_ram_address_ready  output  1  request accepted this cycle when high with data_ram_request.
REQ-014 SHALL have port data_ram_data_ready  output  1  one-cycle response pulse.
REQ-015 SHALL have port data_ram_read_data  output  32  load response word.

Function
REQ-016 SHALL assert data_ram_address_ready when outstanding count < QUEUE_DEPTH (a same-cycle response does not free a slot).
REQ-017 SHALL accept a request on a rising edge where data_ram_request and data_ram_address_ready are both high; at most one acceptance per cycle.
REQ-018 SHALL index memory with data_ram_address[ADDRESS_WIDTH+1:2], ignoring higher bits (address wrap-around) and bits [1:0].
REQ-019 On an accepted store, SHALL update each byte lane i whose strobe bit i is set, in the acceptance cycle; strobe 0000 writes nothing.
REQ-020 On an accepted load, SHALL capture the full memory word at acceptance into the queue entry; a store accepted in an earlier cycle is visible.
REQ-021 SHALL push each accepted request into an in-order queue with a countdown initialised to LATENCY-1.
REQ-022 SHALL decrement every valid entry's countdown each cycle until zero.
REQ-023 SHALL, for a request accepted at edge N, pulse data_ram_data_ready high for exactly the cycle following edge N+LATENCY-1 (i.e., visible LATENCY cycles after acceptance), then pop the entry.
REQ-024 SHALL drive data_ram_read_data with the captured word during a load response and 32'h0 during a store response and when idle.
REQ-025 SHALL support simultaneous push and pop in one cycle; count stays unchanged.
REQ-026 SHALL return responses in acceptance order; back-to-back acceptances yield back-to-back data_ready pulses.
REQ-027 SHALL ignore data_ram_request while address_ready is low; no state change.

Reset
REQ-028 SHALL, on reset assertion (asynchronously), clear queue valid bits and count, drive data_ram_data_ready=0, data_ram_read_data=0, data_ram_address_ready=1 (when the backpressure feature is absent).
REQ-029 SHALL discard outstanding requests on reset mid-operation; no response emitted for them.
REQ-030 SHALL NOT reset memory contents.

Configuration
REQ-031 With DATA_RAM_RESPONDER_BACKPRESSURE_EN defined, SHALL include a free-running 2-bit counter (reset to 0) and force data_ram_address_ready low whenever the counter equals 3, in addition to REQ-016.
REQ-032 Without DATA_RAM_RESPONDER_BACKPRESSURE_EN, SHALL contain no such counter; readiness follows REQ-016 only.

Verification
REQ-033 Store address 0x10, data 0xDEADBEEF, strobe 1111; load 0x10 -> data_ready exactly 2 cycles after load acceptance, read_data 0xDEADBEEF.
REQ-034 Store 0x10 data 0x000000AA strobe 0001 over 0xDEADBEEF -> later load 0x10 returns 0xDEADBEAA; store response read_data 0.
REQ-035 Three consecutive requests held high, QUEUE_DEPTH=2, LATENCY=2 -> address_ready low in cycle 2, third accepted after first pops; three in-order pulses.
REQ-036 Store 0x11223344 to 0x00000004, load 0x00001004 (ADDRESS_WIDTH=10) -> returns 0x11223344 (wrap).
REQ-037 Reset asserted mid-flight with two outstanding loads -> data_ready stays 0 thereafter until a new request.
REQ-038 With DATA_RAM_RESPONDER_BACKPRESSURE_EN, request held high 8 cycles after reset -> address_ready low in cycles 3 and 7 only, 6 acceptances, queue permitting (LATENCY=1).
